isqrt_share_arbiter: RTL and testbench

- Shares one fixed-point inverse-square-root pipeline between N requesters, e.g. the per-ray normalisation units.
- Arbitrates requests round-robin and issues one operand per cycle into the pipeline.
- Carries the requester ID alongside each operand in a tag shift register matched to the pipeline latency.
- Returns each result to its originator; a per-requester credit limit bounds the number of operations in flight.

---
 rtl/isqrt_share_arbiter.sv | 138 +++++++++++++
 tb/tb_isqrt_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_share_arbiter.sv
// isqrt_share_arbiter
//   Shares one fixed-latency inverse-square-root pipeline between N requesters.
//   The arbiter picks requesters round-robin and issues at most one operand per cycle.
//   A tag shift register, matched to the pipeline latency, carries the requester id
//   so that each result is routed back to the requester that issued it.
//   Per-requester credit counters limit how many operations each requester has in flight.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   req_valid[N]       per-requester operand valid
//   req_data[32N]      operands; requester i uses bits [32i+31:32i]
//   req_ready[N]       one-hot grant (combinational)
//   res_valid[N]       one-hot result strobe to the originating requester
//   res_data[32]       result, shared by all requesters
//   pipe_a[32]         operand to the pipeline
//   pipe_new_data      operand strobe to the pipeline
//   pipe_r[32]         pipeline result
//   pipe_output_valid  pipeline result strobe
//   err_sync           sticky flag: pipeline strobe disagrees with the tag pipe
module isqrt_share_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned LAT     = 30,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      res_valid,
  output logic [31:0]       res_data,
  output logic [31:0]       pipe_a,
  output logic              pipe_new_data,
  input  logic [31:0]       pipe_r,
  input  logic              pipe_output_valid,
  output logic              err_sync
);

  localparam int unsigned IdW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW   = $clog2(MAX_OUT + 1);
  localparam int unsigned BlankW = $clog2(LAT + 2);

  logic [IdW-1:0]            ptr_q;
  logic [IdW-1:0]            issue_id_q;
  logic [N-1:0][CntW-1:0]    cnt_q, cnt_d;
  logic [LAT-1:0]            tag_vld_q;
  logic [LAT-1:0][IdW-1:0]   tag_id_q;
  logic [BlankW-1:0]         blank_q;

  logic [N-1:0]              elig;
  logic                      grant_any;
  logic [IdW-1:0]            grant_id;
  logic                      tag_out_vld;
  logic [IdW-1:0]            tag_out_id;
  logic                      ret_fire;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CntW'(MAX_OUT));
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned idx;
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!grant_any && elig[idx]) begin
        grant_any      = 1'b1;
        grant_id       = IdW'(idx);
        req_ready[idx] = 1'b1;
      end
    end
  end

  // The last tag stage lines up with pipe_output_valid for the same operand.
  assign tag_out_vld = tag_vld_q[LAT-1];
  assign tag_out_id  = tag_id_q[LAT-1];
  assign ret_fire    = pipe_output_valid && tag_out_vld;

  // Accept and return on the same requester cancel out.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      unique case ({req_ready[i], res_valid[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= IdW'(N - 1);
      issue_id_q    <= '0;
      pipe_a        <= '0;
      pipe_new_data <= 1'b0;
      cnt_q         <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      res_valid     <= '0;
      res_data      <= '0;
      err_sync      <= 1'b0;
      blank_q       <= BlankW'(LAT + 1);
    end else begin
      cnt_q         <= cnt_d;
      pipe_new_data <= grant_any;
      if (grant_any) begin
        ptr_q      <= grant_id;
        issue_id_q <= grant_id;
        pipe_a     <= req_data[32*grant_id +: 32];
      end

      tag_vld_q <= {tag_vld_q[LAT-2:0], pipe_new_data};
      tag_id_q  <= {tag_id_q[LAT-2:0], issue_id_q};

      if (ret_fire) begin
        res_valid <= N'(1) << tag_out_id;
        res_data  <= pipe_r;
      end else begin
        res_valid <= '0;
      end

      // Results from operations issued before reset emerge untagged during the
      // blanking window; they must not count as a sync error.
      if (blank_q != '0) begin
        blank_q <= blank_q - BlankW'(1);
      end else if (pipe_output_valid != tag_out_vld) begin
        err_sync <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
module tb_isqrt_share_arbiter;

  localparam int N       = 4;
  localparam int LAT     = 30;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      res_valid;
  logic [31:0]       res_data;
  logic [31:0]       pipe_a;
  logic              pipe_new_data;
  logic [31:0]       pipe_r;
  logic              pipe_output_valid;
  logic              err_sync;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic late   = 1'b0;
  logic mon_en = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt_share_arbiter #(.N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .pipe_a            (pipe_a),
    .pipe_new_data     (pipe_new_data),
    .pipe_r            (pipe_r),
    .pipe_output_valid (pipe_output_valid),
    .err_sync          (err_sync)
  );

  // Stub pipeline: fixed latency LAT (or LAT+1 when late), not flushed by reset.
  function automatic logic [31:0] fstub(input logic [31:0] x);
    return ~x + 32'h0000_1234;
  endfunction

  logic [LAT:0]        sv = '0;
  logic [LAT:0][31:0]  sd = '0;
  always @(posedge clk) begin
    sv <= {sv[LAT-1:0], pipe_new_data};
    sd <= {sd[LAT-1:0], fstub(pipe_a)};
  end
  assign pipe_output_valid = late ? sv[LAT] : sv[LAT-1];
  assign pipe_r            = late ? sd[LAT] : sd[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accept predicts one result LAT+2 cycles later.
  typedef struct {
    logic [N-1:0] oh;
    logic [31:0]  d;
    int           c;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (res_valid != '0 && mon_en) begin
        if (q.size() == 0) begin
          check("res_unexpected", 64'(res_valid), 64'(0));
        end else begin
          e = q.pop_front();
          check("res_id", 64'(res_valid), 64'(e.oh));
          check("res_data", 64'(res_data), 64'(e.d));
          check("res_latency", 64'(cyc - e.c), 64'(LAT + 2));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.oh = N'(1) << i;
          e.d  = fstub(req_data[32*i +: 32]);
          e.c  = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_pipe_new_data", 64'(pipe_new_data), 64'(0));
    check("rst_pipe_a", 64'(pipe_a), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_err_sync", 64'(err_sync), 64'(0));
    check("rst_ptr", 64'(dut.ptr_q), 64'(N - 1));
    for (int i = 0; i < N; i++) check("rst_cnt", 64'(dut.cnt_q[i]), 64'(0));
  endtask

  // Credit limit with one requester continuously valid; covers same-cycle
  // accept+return when the counter sits just below the limit.
  task automatic credit_run(input int id);
    int mcnt = 0;
    int both = 0;
    int grants = 0;
    logic acc, dec;
    req_valid = N'(1) << id;
    for (int c = 0; c < 80; c++) begin
      req_data[32*id +: 32] = 32'h0100_0000 + 32'(id * 256 + c);
      @(negedge clk);
      check("credit_ready", 64'(req_ready), (mcnt < MAX_OUT) ? 64'(N'(1) << id) : 64'(0));
      if (c < MAX_OUT) check("credit_first_burst", 64'(req_ready[id]), 64'(1));
      acc = req_ready[id];
      dec = res_valid[id];
      if (acc && dec) both++;
      if (acc) grants++;
      mcnt = mcnt + int'(acc) - int'(dec);
      tick();
      check("credit_cnt", 64'(dut.cnt_q[id]), 64'(mcnt));
    end
    check("credit_same_cycle_seen", 64'(both > 0), 64'(1));
    check("credit_max_cnt_kept", 64'(dut.cnt_q[id] <= MAX_OUT), 64'(1));
    idle(LAT + 6);
    check("credit_drained", 64'(dut.cnt_q[id]), 64'(0));
    check("credit_queue_empty", 64'(q.size()), 64'(0));
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl[19];
  int acc_c;
  bit seen;

  initial begin
    // Request pattern vs. expected grant, starting from reset (ptr = N-1).
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b0000, 4'b0000};
    tbl[5]  = '{4'b1010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};
    tbl[7]  = '{4'b0101, 4'b0001};
    tbl[8]  = '{4'b0101, 4'b0100};
    tbl[9]  = '{4'b0001, 4'b0001};
    tbl[10] = '{4'b0011, 4'b0010};
    tbl[11] = '{4'b1001, 4'b1000};
    tbl[12] = '{4'b1001, 4'b0001};
    tbl[13] = '{4'b0001, 4'b0000};
    tbl[14] = '{4'b1101, 4'b0100};
    tbl[15] = '{4'b1101, 4'b1000};
    tbl[16] = '{4'b1101, 4'b0100};
    tbl[17] = '{4'b1111, 4'b0010};
    tbl[18] = '{4'b1111, 4'b0000};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state();
    tick();

    // Single op from requester 2.
    idle(3);
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'h0004_0000;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_pnd", 64'(pipe_new_data), 64'(1));
    check("single_pipe_a", 64'(pipe_a), 64'h0004_0000);
    tick();
    @(negedge clk);
    check("single_pnd_pulse", 64'(pipe_new_data), 64'(0));
    check("single_pipe_a_hold", 64'(pipe_a), 64'h0004_0000);
    idle(LAT + 6);
    check("single_queue_empty", 64'(q.size()), 64'(0));

    // Table-driven arbitration and credit masking.
    do_reset();
    for (int r = 0; r < 19; r++) begin
      req_valid = tbl[r].v;
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(r * 16 + i + 32'h00A0_0000);
      @(negedge clk);
      check("table_grant", 64'(req_ready), 64'(tbl[r].exp));
      tick();
    end
    idle(LAT + 6);
    check("table_queue_empty", 64'(q.size()), 64'(0));

    // Fairness: all requesters valid for 16 cycles.
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(c * 16 + i + 32'h00F0_0000);
      @(negedge clk);
      check("fair_grant", 64'(req_ready), 64'(N'(1) << (c % N)));
      tick();
    end
    @(negedge clk);
    check("fair_all_full", 64'(req_ready), 64'(0));
    idle(LAT + 6);
    check("fair_queue_empty", 64'(q.size()), 64'(0));

    // Credit limit on requester 1, then same-cycle accept/return on requester 3.
    do_reset();
    credit_run(1);
    do_reset();
    credit_run(3);

    // Reset with three operations in flight.
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      req_data[31:0] = 32'(32'h0055_0000 + c);
      tick();
    end
    idle(10);
    do_reset();
    check_reset_state();
    idle(LAT + 8);
    @(negedge clk);
    check("flight_no_err", 64'(err_sync), 64'(0));
    check("flight_no_res", 64'(res_valid), 64'(0));
    tick();
    req_valid = 4'b1000;
    req_data[96 +: 32] = 32'h0012_3456;
    @(negedge clk);
    check("flight_new_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    idle(LAT + 6);
    check("flight_queue_empty", 64'(q.size()), 64'(0));
    check("flight_no_err_after", 64'(err_sync), 64'(0));

    // Sync error: pipeline strobe one cycle late.
    late = 1'b1;
    mon_en = 1'b0;
    do_reset();
    idle(2);
    req_valid = 4'b0001;
    req_data[31:0] = 32'h0000_0100;
    @(negedge clk);
    acc_c = cyc;
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 20 && !seen; c++) begin
      @(negedge clk);
      if (err_sync) begin
        seen = 1'b1;
        check("sync_err_time", 64'(cyc - acc_c), 64'(LAT + 2));
      end
      tick();
    end
    check("sync_err_seen", 64'(seen), 64'(1));
    idle(15);
    @(negedge clk);
    check("sync_err_sticky", 64'(err_sync), 64'(1));
    check("sync_no_res", 64'(res_valid), 64'(0));
    tick();
    late = 1'b0;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    check("sync_err_cleared", 64'(err_sync), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
